// File: rtl/pe_decoder_2x4.sv
// ---------------------------------------------------------------------------
// pe_decoder_2x4
//   Registered 2-to-4 decoder, the inverse of the 4x2 priority encoder.
//   An encoded word {y1,y0,v} is taken through a valid/ready handshake. The
//   matching one-hot request line (or no line, for v=0) is then driven for
//   HOLD_CYCLES cycles. One mandatory IDLE cycle follows before the next word.
//
// Parameters
//   HOLD_CYCLES : cycles each decoded word is held (>= 1)
//   CNT_W       : width of the saturating decode counter
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_valid   in   encoded word present on y1,y0,v
//   in_ready   out  high in IDLE; the block can accept a word
//   y1,y0      in   encoded index, y1 = MSB
//   v          in   encoded valid, 0 = no input active
//   a0..a3     out  decoded one-hot lines, a3 = highest index
//   out_valid  out  a3..a0 carry a decoded word
//   dec_count  out  accepted words with v=1, saturating at all-ones
//   chk_err    out  sticky round-trip check error
//
// Optional feature
//   Define PE_DEC_ROUNDTRIP_CHECK_EN to build the round-trip checker. The
//   checker re-encodes a3..a0 during HOLD and compares the result with the
//   accepted word. When the macro is undefined, chk_err is tied to 0.
// ---------------------------------------------------------------------------
module pe_decoder_2x4 #(
    parameter int HOLD_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             y1,
    input  logic             y0,
    input  logic             v,
    output logic             a0,
    output logic             a1,
    output logic             a2,
    output logic             a3,
    output logic             out_valid,
    output logic [CNT_W-1:0] dec_count,
    output logic             chk_err
);

    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [HC_W-1:0]  hold_q, hold_d;
    logic [3:0]       a_q, a_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    // Decode {y1,y0,v}: one-hot on the index when v=1, all-zero when v=0.
    // A shift is used so that X on the index propagates unchanged.
    function automatic logic [3:0] decode(input logic [1:0] idx, input logic vld);
        decode = vld ? (4'b0001 << idx) : 4'b0000;
    endfunction

    // Saturating increment; the counter stops at all-ones and never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        sat_inc = (&c) ? c : c + CNT_W'(1);
    endfunction

    assign accept = in_valid & (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        a_d         = a_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                a_d         = 4'b0000;
                out_valid_d = 1'b0;
                if (accept) begin
                    state_d     = HOLD;
                    hold_d      = HOLD_LOAD;
                    a_d         = decode({y1, y0}, v);
                    out_valid_d = 1'b1;
                    if (v) begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
            end
            HOLD: begin
                // Leaving on hold_q==0 yields exactly HOLD_CYCLES HOLD cycles.
                if (hold_q == '0) begin
                    state_d     = IDLE;
                    a_d         = 4'b0000;
                    out_valid_d = 1'b0;
                end else begin
                    hold_d = hold_q - HC_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                a_d         = 4'b0000;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            a_q         <= 4'b0000;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            a_q         <= a_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready         = (state_q == IDLE);
    assign {a3, a2, a1, a0} = a_q;
    assign out_valid        = out_valid_q;
    assign dec_count        = cnt_q;

`ifdef PE_DEC_ROUNDTRIP_CHECK_EN
    logic [2:0] word_q;
    logic       chk_q;
    logic [2:0] reenc;
    logic       mismatch;

    // Priority re-encode: a3 > a2 > a1 > a0; no line high -> y=00, v=0.
    function automatic logic [2:0] encode(input logic [3:0] a);
        if (a[3])      encode = 3'b111;
        else if (a[2]) encode = 3'b101;
        else if (a[1]) encode = 3'b011;
        else if (a[0]) encode = 3'b001;
        else           encode = 3'b000;
    endfunction

    // The word is needed only for the comparison, so it is not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            word_q <= {y1, y0, v};
        end
    end

    // A v=0 word carries no meaningful index, so only v is compared.
    assign reenc    = encode(a_q);
    assign mismatch = (reenc[0] != word_q[0]) ||
                      (word_q[0] && (reenc[2:1] != word_q[2:1]));

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q <= 1'b0;
        end else if ((state_q == HOLD) && mismatch) begin
            chk_q <= 1'b1;
        end
    end

    assign chk_err = chk_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_pe_decoder_2x4.sv
// ---------------------------------------------------------------------------
// tb_pe_decoder_2x4
//   Four decoder instances with different HOLD_CYCLES/CNT_W settings share one
//   clock and reset. Each test task drives one instance at the negative edge,
//   pushes the expected post-edge outputs to a scoreboard queue and pops and
//   compares them at the next negative edge.
// ---------------------------------------------------------------------------
module tb_pe_decoder_2x4;

    typedef struct packed {
        logic       rst;
        logic       iv;
        logic [1:0] y;
        logic       v;
    } stim_t;

    typedef struct packed {
        logic [3:0] a;
        logic       ov;
        logic       rdy;
        logic [7:0] cnt;
        logic       chk;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       iv [4];
    logic [1:0] ys [4];
    logic       vs [4];

    logic       rdy0, rdy1, rdy2, rdy3;
    wire  [3:0] a_0, a_1, a_2, a_3;
    logic       ov0, ov1, ov2, ov3;
    logic [7:0] cnt0, cnt1, cnt2;
    logic [1:0] cntc;
    logic       chk0, chk1, chk2, chk3;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    pe_decoder_2x4 #(.HOLD_CYCLES(1), .CNT_W(8)) d0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy0),
        .y1(ys[0][1]), .y0(ys[0][0]), .v(vs[0]),
        .a0(a_0[0]), .a1(a_0[1]), .a2(a_0[2]), .a3(a_0[3]),
        .out_valid(ov0), .dec_count(cnt0), .chk_err(chk0));

    pe_decoder_2x4 #(.HOLD_CYCLES(3), .CNT_W(8)) d1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy1),
        .y1(ys[1][1]), .y0(ys[1][0]), .v(vs[1]),
        .a0(a_1[0]), .a1(a_1[1]), .a2(a_1[2]), .a3(a_1[3]),
        .out_valid(ov1), .dec_count(cnt1), .chk_err(chk1));

    pe_decoder_2x4 #(.HOLD_CYCLES(4), .CNT_W(8)) d2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy2),
        .y1(ys[2][1]), .y0(ys[2][0]), .v(vs[2]),
        .a0(a_2[0]), .a1(a_2[1]), .a2(a_2[2]), .a3(a_2[3]),
        .out_valid(ov2), .dec_count(cnt2), .chk_err(chk2));

    pe_decoder_2x4 #(.HOLD_CYCLES(1), .CNT_W(2)) d3 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(rdy3),
        .y1(ys[3][1]), .y0(ys[3][0]), .v(vs[3]),
        .a0(a_3[0]), .a1(a_3[1]), .a2(a_3[2]), .a3(a_3[3]),
        .out_valid(ov3), .dec_count(cntc), .chk_err(chk3));

    function automatic exp_t obs(input int idx);
        case (idx)
            0:       obs = '{a_0, ov0, rdy0, cnt0, chk0};
            1:       obs = '{a_1, ov1, rdy1, cnt1, chk1};
            2:       obs = '{a_2, ov2, rdy2, cnt2, chk2};
            default: obs = '{a_3, ov3, rdy3, {6'b0, cntc}, chk3};
        endcase
    endfunction

    // Both reset cycles elapse before the sample; every instance must be at reset values.
    task automatic test_reset();
        exp_t e, o;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back('{4'b0000, 1'b0, 1'b1, 8'd0, 1'b0});
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            o = obs(k);
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset dut%0d: got {a,ov,rdy,cnt,chk}=%b expected %b", k, o, e);
            end
        end
    endtask

    // HOLD_CYCLES=1, y=10 v=1: a2 for one cycle, then back to IDLE.
    task automatic test_hold1();
        stim_t st[2];
        exp_t  ex[2];
        exp_t  e, o;
        st = '{'{1'b0, 1'b1, 2'b10, 1'b1}, '{1'b0, 1'b0, 2'b00, 1'b0}};
        ex = '{'{4'b0100, 1'b1, 1'b0, 8'd1, 1'b0}, '{4'b0000, 1'b0, 1'b1, 8'd1, 1'b0}};
        for (int i = 0; i < 2; i++) begin
            rst = st[i].rst; iv[0] = st[i].iv; ys[0] = st[i].y; vs[0] = st[i].v;
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs(0);
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL hold1 cyc%0d: got {a,ov,rdy,cnt,chk}=%b expected %b", i, o, e);
            end
        end
    endtask

    // v=0 word: valid output with all lines low, counter unchanged.
    task automatic test_v0();
        stim_t st[2];
        exp_t  ex[2];
        exp_t  e, o;
        st = '{'{1'b0, 1'b1, 2'b11, 1'b0}, '{1'b0, 1'b0, 2'b00, 1'b0}};
        ex = '{'{4'b0000, 1'b1, 1'b0, 8'd1, 1'b0}, '{4'b0000, 1'b0, 1'b1, 8'd1, 1'b0}};
        for (int i = 0; i < 2; i++) begin
            rst = st[i].rst; iv[0] = st[i].iv; ys[0] = st[i].y; vs[0] = st[i].v;
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs(0);
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL v0 cyc%0d: got {a,ov,rdy,cnt,chk}=%b expected %b", i, o, e);
            end
        end
    endtask

    // in_valid held high: accepts only every other cycle with HOLD_CYCLES=1.
    task automatic test_back_to_back();
        stim_t st[5];
        exp_t  ex[5];
        exp_t  e, o;
        st = '{'{1'b0, 1'b1, 2'b00, 1'b1}, '{1'b0, 1'b1, 2'b00, 1'b1},
               '{1'b0, 1'b1, 2'b00, 1'b1}, '{1'b0, 1'b0, 2'b00, 1'b0},
               '{1'b0, 1'b0, 2'b00, 1'b0}};
        ex = '{'{4'b0001, 1'b1, 1'b0, 8'd2, 1'b0}, '{4'b0000, 1'b0, 1'b1, 8'd2, 1'b0},
               '{4'b0001, 1'b1, 1'b0, 8'd3, 1'b0}, '{4'b0000, 1'b0, 1'b1, 8'd3, 1'b0},
               '{4'b0000, 1'b0, 1'b1, 8'd3, 1'b0}};
        for (int i = 0; i < 5; i++) begin
            rst = st[i].rst; iv[0] = st[i].iv; ys[0] = st[i].y; vs[0] = st[i].v;
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs(0);
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b cyc%0d: got {a,ov,rdy,cnt,chk}=%b expected %b", i, o, e);
            end
        end
    endtask

    // HOLD_CYCLES=3: a1 held 3 cycles, one IDLE cycle, then y=11 accepted.
    task automatic test_hold3();
        stim_t st[8];
        exp_t  ex[8];
        exp_t  e, o;
        st = '{'{1'b0, 1'b1, 2'b01, 1'b1}, '{1'b0, 1'b1, 2'b11, 1'b1},
               '{1'b0, 1'b1, 2'b11, 1'b1}, '{1'b0, 1'b1, 2'b11, 1'b1},
               '{1'b0, 1'b1, 2'b11, 1'b1}, '{1'b0, 1'b0, 2'b00, 1'b0},
               '{1'b0, 1'b0, 2'b00, 1'b0}, '{1'b0, 1'b0, 2'b00, 1'b0}};
        ex = '{'{4'b0010, 1'b1, 1'b0, 8'd1, 1'b0}, '{4'b0010, 1'b1, 1'b0, 8'd1, 1'b0},
               '{4'b0010, 1'b1, 1'b0, 8'd1, 1'b0}, '{4'b0000, 1'b0, 1'b1, 8'd1, 1'b0},
               '{4'b1000, 1'b1, 1'b0, 8'd2, 1'b0}, '{4'b1000, 1'b1, 1'b0, 8'd2, 1'b0},
               '{4'b1000, 1'b1, 1'b0, 8'd2, 1'b0}, '{4'b0000, 1'b0, 1'b1, 8'd2, 1'b0}};
        for (int i = 0; i < 8; i++) begin
            rst = st[i].rst; iv[1] = st[i].iv; ys[1] = st[i].y; vs[1] = st[i].v;
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs(1);
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL hold3 cyc%0d: got {a,ov,rdy,cnt,chk}=%b expected %b", i, o, e);
            end
        end
    endtask

    // CNT_W=2: five v=1 words, counter reads 1,2,3,3,3.
    task automatic test_saturate();
        exp_t e, o, x;
        int   w;
        for (int k = 0; k < 10; k++) begin
            w = k / 2;
            rst = 1'b0; iv[3] = 1'b1; ys[3] = 2'(w % 4); vs[3] = 1'b1;
            x.a   = (k % 2 == 0) ? (4'b0001 << (w % 4)) : 4'b0000;
            x.ov  = (k % 2 == 0);
            x.rdy = (k % 2 != 0);
            x.cnt = (w + 1 > 3) ? 8'd3 : 8'(w + 1);
            x.chk = 1'b0;
            exp_q.push_back(x);
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs(3);
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL saturate cyc%0d: got {a,ov,rdy,cnt,chk}=%b expected %b", k, o, e);
            end
        end
        iv[3] = 1'b0;
    endtask

    // HOLD_CYCLES=4: reset on the 2nd HOLD cycle, then reset beating an accept in IDLE.
    task automatic test_mid_reset();
        stim_t st[6];
        exp_t  ex[6];
        exp_t  e, o;
        st = '{'{1'b0, 1'b1, 2'b10, 1'b1}, '{1'b0, 1'b0, 2'b00, 1'b0},
               '{1'b1, 1'b1, 2'b10, 1'b1}, '{1'b0, 1'b0, 2'b00, 1'b0},
               '{1'b1, 1'b1, 2'b11, 1'b1}, '{1'b0, 1'b0, 2'b00, 1'b0}};
        ex = '{'{4'b0100, 1'b1, 1'b0, 8'd1, 1'b0}, '{4'b0100, 1'b1, 1'b0, 8'd1, 1'b0},
               '{4'b0000, 1'b0, 1'b1, 8'd0, 1'b0}, '{4'b0000, 1'b0, 1'b1, 8'd0, 1'b0},
               '{4'b0000, 1'b0, 1'b1, 8'd0, 1'b0}, '{4'b0000, 1'b0, 1'b1, 8'd0, 1'b0}};
        for (int i = 0; i < 6; i++) begin
            rst = st[i].rst; iv[2] = st[i].iv; ys[2] = st[i].y; vs[2] = st[i].v;
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs(2);
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL midrst cyc%0d: got {a,ov,rdy,cnt,chk}=%b expected %b", i, o, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            iv[k] = 1'b0; ys[k] = 2'b00; vs[k] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_hold1();
        test_v0();
        test_back_to_back();
        test_hold3();
        test_saturate();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
